// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I data-memory access unit with req/gnt/rvalid bus handshake
// Aligns store lanes, extracts and extends load data, and stalls the pipeline while an access is in flight.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_stall,
  output logic                  o_misaligned,
  output logic                  o_bus_req,
  output logic                  o_bus_we,
  output logic [ADDR_WIDTH-1:0] o_bus_addr,
  output logic [DATA_WIDTH-1:0] o_bus_wdata,
  output logic [3:0]            o_bus_be,
  input  logic                  i_bus_gnt,
  input  logic                  i_bus_rvalid,
  input  logic [DATA_WIDTH-1:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic                  access;
  logic                  is_store;
  logic                  legal;
  logic                  accept;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic [3:0]            be_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            offset_q;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] extracted;

  assign access   = i_mem_read | i_mem_write;
  assign is_store = i_mem_write;
  assign accept   = access & legal;

  // Size/alignment legality; stores only allow B/H/W encodings.
  always_comb begin
    legal = 1'b0;
    if (is_store) begin
      case (i_funct3)
        3'b000:  legal = 1'b1;
        3'b001:  legal = ~i_addr[0];
        3'b010:  legal = (i_addr[1:0] == 2'b00);
        default: legal = 1'b0;
      endcase
    end else begin
      case (i_funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~i_addr[0];
        3'b010:         legal = (i_addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end
  end

  // Store data is replicated across lanes so the byte enables alone select the target bytes.
  always_comb begin
    wdata_d = '0;
    be_d    = 4'b1111;
    if (is_store) begin
      case (i_funct3)
        3'b000: begin
          wdata_d = {4{i_store_data[7:0]}};
          be_d    = 4'b0001 << i_addr[1:0];
        end
        3'b001: begin
          wdata_d = {2{i_store_data[15:0]}};
          be_d    = 4'b0011 << i_addr[1:0];
        end
        default: begin
          wdata_d = i_store_data;
          be_d    = 4'b1111;
        end
      endcase
    end
  end

  assign shifted = i_bus_rdata >> {offset_q, 3'b000};

  always_comb begin
    extracted = i_bus_rdata;
    case (funct3_q)
      3'b000:  extracted = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  extracted = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  extracted = {24'h000000, shifted[7:0]};
      3'b101:  extracted = {16'h0000, shifted[15:0]};
      default: extracted = i_bus_rdata;
    endcase
  end

  // Stall and misaligned are gated by reset so both read 0 while held in reset.
  always_comb begin
    state_d      = state_q;
    o_stall      = 1'b0;
    o_misaligned = 1'b0;
    case (state_q)
      IDLE: begin
        o_stall      = accept & i_rst_n;
        o_misaligned = access & ~legal & i_rst_n;
        if (accept) state_d = REQ;
      end
      REQ: begin
        o_stall = 1'b1;
        if (i_bus_gnt) state_d = we_q ? DONE : WAIT;
      end
      WAIT: begin
        o_stall = 1'b1;
        if (i_bus_rvalid) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      offset_q    <= 2'b00;
      o_bus_req   <= 1'b0;
      o_bus_we    <= 1'b0;
      o_bus_addr  <= '0;
      o_bus_wdata <= '0;
      o_bus_be    <= 4'b0000;
      o_load_data <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q        <= is_store;
            funct3_q    <= i_funct3;
            offset_q    <= i_addr[1:0];
            o_bus_req   <= 1'b1;
            o_bus_we    <= is_store;
            o_bus_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
            o_bus_wdata <= wdata_d;
            o_bus_be    <= be_d;
          end
        end
        REQ: begin
          if (i_bus_gnt) o_bus_req <= 1'b0;
        end
        WAIT: begin
          if (i_bus_rvalid) o_load_data <= extracted;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] sd;
  logic [31:0] load_data;
  logic        stall;
  logic        misaligned;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_mem_read   (mem_read),
    .i_mem_write  (mem_write),
    .i_funct3     (funct3),
    .i_addr       (addr),
    .i_store_data (sd),
    .o_load_data  (load_data),
    .o_stall      (stall),
    .o_misaligned (misaligned),
    .o_bus_req    (bus_req),
    .o_bus_we     (bus_we),
    .o_bus_addr   (bus_addr),
    .o_bus_wdata  (bus_wdata),
    .o_bus_be     (bus_be),
    .i_bus_gnt    (gnt),
    .i_bus_rvalid (rvalid),
    .i_bus_rdata  (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Entered 1 time unit after a rising edge; returns in the DONE cycle (or the rejecting IDLE cycle).
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                            input int gnt_dly, input int rv_dly, input logic [31:0] rd_word,
                            output int stall_n, output logic [31:0] ba, output logic [3:0] bb,
                            output logic [31:0] bw, output logic bwe);
    int req_n;
    int wait_n;
    bit granted;
    bit seen;
    bit done;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    sd        = d;
    stall_n = 0; req_n = 0; wait_n = 0;
    granted = 0; seen = 0; done = 0;
    ba = 0; bb = 0; bw = 0; bwe = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      #2;
      if (!stall) begin
        done = 1;
      end else begin
        stall_n++;
        if (bus_req) begin
          if (!seen) begin
            seen = 1; ba = bus_addr; bb = bus_be; bw = bus_wdata; bwe = bus_we;
          end else begin
            check_eq($sformatf("%s_addr_stable", tag), bus_addr, ba);
            check_eq($sformatf("%s_be_stable", tag), {28'h0, bus_be}, {28'h0, bb});
            check_eq($sformatf("%s_we_stable", tag), {31'h0, bus_we}, {31'h0, bwe});
          end
          if (req_n == gnt_dly) begin
            gnt = 1'b1;
            granted = 1;
          end
          req_n++;
        end else if (granted) begin
          if (wait_n == rv_dly) begin
            rvalid = 1'b1;
            rdata  = rd_word;
          end
          wait_n++;
        end
        @(posedge clk);
        #1;
        gnt    = 1'b0;
        rvalid = 1'b0;
      end
    end
    if (!done) check_eq($sformatf("%s_timeout", tag), 32'h0, 32'h1);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_illegal(input string tag, input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a);
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    addr      = a;
    #2;
    check_eq($sformatf("%s_misaligned", tag), {31'h0, misaligned}, 32'h1);
    check_eq($sformatf("%s_stall", tag), {31'h0, stall}, 32'h0);
    check_eq($sformatf("%s_req", tag), {31'h0, bus_req}, 32'h0);
    next_cycle();
    check_eq($sformatf("%s_req_after", tag), {31'h0, bus_req}, 32'h0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check_eq($sformatf("%s_misaligned_clear", tag), {31'h0, misaligned}, 32'h0);
    next_cycle();
  endtask

  int          st;
  logic [31:0] ba;
  logic [3:0]  bb;
  logic [31:0] bw;
  logic        bwe;

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; sd = 32'h0; gnt = 1'b0; rvalid = 1'b0; rdata = 32'h0;
    mem_read = 1'b1; funct3 = 3'b010;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", {31'h0, bus_req}, 32'h0);
    check_eq("rst_we", {31'h0, bus_we}, 32'h0);
    check_eq("rst_addr", bus_addr, 32'h0);
    check_eq("rst_wdata", bus_wdata, 32'h0);
    check_eq("rst_be", {28'h0, bus_be}, 32'h0);
    check_eq("rst_load", load_data, 32'h0);
    check_eq("rst_stall", {31'h0, stall}, 32'h0);
    check_eq("rst_misaligned", {31'h0, misaligned}, 32'h0);
    mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    next_cycle();

    run_access("lw", 1, 0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, st, ba, bb, bw, bwe);
    check_eq("lw_stall", st, 3);
    check_eq("lw_data", load_data, 32'hDEADBEEF);
    check_eq("lw_addr", ba, 32'h100);
    check_eq("lw_be", {28'h0, bb}, 32'hF);
    check_eq("lw_we", {31'h0, bwe}, 32'h0);
    next_cycle();
    check_eq("lw_after_req", {31'h0, bus_req}, 32'h0);

    run_access("lb", 1, 0, 3'b000, 32'h203, 32'h0, 0, 0, 32'h80112233, st, ba, bb, bw, bwe);
    check_eq("lb_data", load_data, 32'hFFFFFF80);
    check_eq("lb_addr", ba, 32'h200);
    next_cycle();
    run_access("lbu", 1, 0, 3'b100, 32'h203, 32'h0, 0, 0, 32'h80112233, st, ba, bb, bw, bwe);
    check_eq("lbu_data", load_data, 32'h00000080);
    next_cycle();
    run_access("lh", 1, 0, 3'b001, 32'h200, 32'h0, 0, 0, 32'h80118233, st, ba, bb, bw, bwe);
    check_eq("lh_data", load_data, 32'hFFFF8233);
    next_cycle();
    run_access("lhu", 1, 0, 3'b101, 32'h202, 32'h0, 0, 0, 32'h80112233, st, ba, bb, bw, bwe);
    check_eq("lhu_data", load_data, 32'h00008011);
    next_cycle();

    run_access("sb", 0, 1, 3'b000, 32'h301, 32'h000000A5, 0, 0, 32'h0, st, ba, bb, bw, bwe);
    check_eq("sb_stall", st, 2);
    check_eq("sb_addr", ba, 32'h300);
    check_eq("sb_be", {28'h0, bb}, 32'h2);
    check_eq("sb_wdata", bw, 32'hA5A5A5A5);
    check_eq("sb_we", {31'h0, bwe}, 32'h1);
    next_cycle();
    run_access("sh", 0, 1, 3'b001, 32'h302, 32'h00001234, 0, 0, 32'h0, st, ba, bb, bw, bwe);
    check_eq("sh_be", {28'h0, bb}, 32'hC);
    check_eq("sh_wdata", bw, 32'h12341234);
    next_cycle();
    run_access("sw", 1, 1, 3'b010, 32'h500, 32'hCAFEF00D, 0, 0, 32'h0, st, ba, bb, bw, bwe);
    check_eq("sw_be", {28'h0, bb}, 32'hF);
    check_eq("sw_wdata", bw, 32'hCAFEF00D);
    check_eq("sw_we", {31'h0, bwe}, 32'h1);
    check_eq("store_keeps_load", load_data, 32'h00008011);
    next_cycle();

    check_illegal("lh_mis", 1, 0, 3'b001, 32'h401);
    check_illegal("sw_mis", 0, 1, 3'b010, 32'h402);
    check_illegal("ld_f3_011", 1, 0, 3'b011, 32'h0);
    check_illegal("st_f3_100", 0, 1, 3'b100, 32'h0);

    run_access("lw_slow", 1, 0, 3'b010, 32'h600, 32'h0, 3, 1, 32'h0BADF00D, st, ba, bb, bw, bwe);
    check_eq("lw_slow_stall", st, 7);
    check_eq("lw_slow_data", load_data, 32'h0BADF00D);
    check_eq("lw_slow_addr", ba, 32'h600);
    next_cycle();
    check_eq("lw_slow_single_done", {31'h0, stall}, 32'h0);

    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h700;
    #2;
    check_eq("rstw_accept_stall", {31'h0, stall}, 32'h1);
    next_cycle();
    #2;
    gnt = 1'b1;
    next_cycle();
    gnt = 1'b0;
    #2;
    check_eq("rstw_wait_stall", {31'h0, stall}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_eq("rstw_req", {31'h0, bus_req}, 32'h0);
    check_eq("rstw_stall", {31'h0, stall}, 32'h0);
    check_eq("rstw_addr", bus_addr, 32'h0);
    check_eq("rstw_load", load_data, 32'h0);
    mem_read = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    #1;
    rvalid = 1'b1;
    rdata  = 32'h12345678;
    next_cycle();
    rvalid = 1'b0;
    check_eq("stray_load", load_data, 32'h0);
    check_eq("stray_stall", {31'h0, stall}, 32'h0);
    check_eq("stray_req", {31'h0, bus_req}, 32'h0);
    next_cycle();

    run_access("lw_post", 1, 0, 3'b010, 32'h800, 32'h0, 1, 0, 32'h55AA55AA, st, ba, bb, bw, bwe);
    check_eq("lw_post_stall", st, 4);
    check_eq("lw_post_data", load_data, 32'h55AA55AA);
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
